pattern_gen: RTL and testbench

PATTERN_GEN -- requirements
Module: pattern_gen

---
 rtl/pattern_gen.sv | 152 +++++++++++++++
 tb/tb_pattern_gen.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_gen.sv
// Raster timing generator producing bars / ramp / checker / scroll test patterns.
// Define PATTERN_GEN_BAYER_EN to invert bars and ramp at odd-row/odd-col sites (B of RGGB).
module pattern_gen #(
   parameter int PIX_W = 10,
   parameter int HPIX  = 640,
   parameter int VPIX  = 400,
   parameter int HSYNC = 44,
   parameter int HBP   = 64,
   parameter int HFP   = 64,
   parameter int VSYNC = 5,
   parameter int VBP   = 2,
   parameter int VFP   = 1,
   parameter int BAR_W = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic [1:0]       mode,
   output logic             fv,
   output logic             lv,
   output logic             pix_en,
   output logic [PIX_W-1:0] pix_data,
   output logic [15:0]      frame_count,
   output logic             frame_done,
   output logic [1:0]       state_dbg
);

   localparam int HTOT   = HSYNC + HBP + HPIX + HFP;
   localparam int VTOT   = VSYNC + VBP + VPIX + VFP;
   localparam int XW     = $clog2(HTOT + 1);
   localparam int YW     = $clog2(VTOT + 1);
   localparam int BAR_SH = $clog2(BAR_W);

   localparam logic [XW-1:0] X_LAST = XW'(HTOT - 1);
   localparam logic [XW-1:0] X_LV   = XW'(HSYNC);
   localparam logic [XW-1:0] X_ACT0 = XW'(HSYNC + HBP);
   localparam logic [XW-1:0] X_ACT1 = XW'(HSYNC + HBP + HPIX);
   localparam logic [YW-1:0] Y_LAST = YW'(VTOT - 1);
   localparam logic [YW-1:0] Y_FV   = YW'(VSYNC);
   localparam logic [YW-1:0] Y_ACT0 = YW'(VSYNC + VBP);
   localparam logic [YW-1:0] Y_ACT1 = YW'(VSYNC + VBP + VPIX);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [XW-1:0]   x, x_nxt;
   logic [YW-1:0]   y, y_nxt;
   logic [1:0]      mode_q;
   logic            line_end, frame_end, running;

   assign line_end  = (x == X_LAST);
   assign frame_end = line_end && (y == Y_LAST);
   assign running   = (state != IDLE);
   assign state_dbg = state;

   // enable only decides whether another frame follows; a started frame always completes.
   always_comb begin
      state_nxt = state;
      x_nxt     = x;
      y_nxt     = y;
      case (state)
         IDLE: begin
            x_nxt = '0;
            y_nxt = '0;
            if (enable) state_nxt = RUN;
         end
         RUN, STOPPING: begin
            if (line_end) begin
               x_nxt = '0;
               y_nxt = (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
               x_nxt = x + 1'b1;
            end
            if (frame_end) begin
               if (state == STOPPING || !enable) state_nxt = IDLE;
            end else if (state == RUN && !enable) begin
               state_nxt = STOPPING;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         x      <= '0;
         y      <= '0;
         mode_q <= 2'd0;
      end else begin
         state <= state_nxt;
         x     <= x_nxt;
         y     <= y_nxt;
         if (running && x == '0 && y == '0) mode_q <= mode;
      end
   end

   logic [XW-1:0]    col;
   logic [YW-1:0]    row;
   logic [31:0]      col32, row32;
   logic [2:0]       bar_idx;
   logic             act_ln, fv_c, lv_c, pe_c;
   logic [PIX_W-1:0] pd_c;

   assign col     = x - X_ACT0;
   assign row     = y - Y_ACT0;
   assign col32   = 32'(col);
   assign row32   = 32'(row);
   assign bar_idx = 3'(col >> BAR_SH);

   always_comb begin
      act_ln = running && (y >= Y_ACT0) && (y < Y_ACT1);
      fv_c   = running && (y >= Y_FV);
      lv_c   = act_ln && (x >= X_LV);
      pe_c   = act_ln && (x >= X_ACT0) && (x < X_ACT1);
      pd_c   = '0;
      case (mode_q)
         2'd0:    pd_c = {bar_idx, {(PIX_W-3){1'b0}}};
         2'd1:    pd_c = PIX_W'(col32);
         2'd2:    pd_c = {PIX_W{col32[3] ^ row32[3]}};
         default: pd_c = PIX_W'(col32 + row32 + {16'd0, frame_count});
      endcase
`ifdef PATTERN_GEN_BAYER_EN
      if (!mode_q[1] && col32[0] && row32[0]) pd_c = ~pd_c;
`endif
      if (!pe_c) pd_c = '0;
   end

   // One register stage keeps every output aligned to the (x,y) that produced it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fv          <= 1'b0;
         lv          <= 1'b0;
         pix_en      <= 1'b0;
         pix_data    <= '0;
         frame_done  <= 1'b0;
         frame_count <= 16'd0;
      end else begin
         fv         <= fv_c;
         lv         <= lv_c;
         pix_en     <= pe_c;
         pix_data   <= pd_c;
         frame_done <= running && frame_end;
         if (running && frame_end) frame_count <= frame_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_pattern_gen.sv
// Bench for pattern_gen: expected raster derived per frame cycle from the timing and pattern rules.
module tb_pattern_gen;

   localparam int PIX_W = 10;
   localparam int HPIX  = 64;
   localparam int VPIX  = 4;
   localparam int HSYNC = 2;
   localparam int HBP   = 2;
   localparam int HFP   = 2;
   localparam int VSYNC = 1;
   localparam int VBP   = 1;
   localparam int VFP   = 1;
   localparam int BAR_W = 32;
   localparam int HTOT  = HSYNC + HBP + HPIX + HFP;
   localparam int VTOT  = VSYNC + VBP + VPIX + VFP;
   localparam int FTOT  = HTOT * VTOT;
   localparam int VW    = PIX_W + 20;

   logic             clk;
   logic             reset_n;
   logic             enable;
   logic [1:0]       mode;
   logic             fv, lv, pix_en, frame_done;
   logic [PIX_W-1:0] pix_data;
   logic [15:0]      frame_count;
   logic [1:0]       state_dbg;

   int total;
   int bad;
   int fc_model;
   int mode_seq[8];

   pattern_gen #(
      .PIX_W(PIX_W), .HPIX(HPIX), .VPIX(VPIX), .HSYNC(HSYNC), .HBP(HBP), .HFP(HFP),
      .VSYNC(VSYNC), .VBP(VBP), .VFP(VFP), .BAR_W(BAR_W)
   ) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode),
      .fv(fv), .lv(lv), .pix_en(pix_en), .pix_data(pix_data),
      .frame_count(frame_count), .frame_done(frame_done), .state_dbg(state_dbg)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected {fv, lv, pix_en, frame_done, frame_count, pix_data} for frame cycle k.
   function automatic logic [VW-1:0] exp_vec(input int k, input int m, input int fc);
      int x, y, col, row, pd, fce;
      bit fv_e, act, lv_e, pe_e, fd_e;
      logic [15:0] fc16;
      logic [PIX_W-1:0] pd_v;
      x    = k % HTOT;
      y    = k / HTOT;
      col  = x - (HSYNC + HBP);
      row  = y - (VSYNC + VBP);
      fv_e = (y >= VSYNC);
      act  = (y >= VSYNC + VBP) && (y < VSYNC + VBP + VPIX);
      lv_e = act && (x >= HSYNC);
      pe_e = act && (x >= HSYNC + HBP) && (x < HSYNC + HBP + HPIX);
      fd_e = (k == FTOT - 1);
      case (m)
         0:       pd = ((col / BAR_W) % 8) * (1 << (PIX_W - 3));
         1:       pd = col % (1 << PIX_W);
         2:       pd = (((col / 8) % 2) != ((row / 8) % 2)) ? (1 << PIX_W) - 1 : 0;
         default: pd = (col + row + fc) % (1 << PIX_W);
      endcase
`ifdef PATTERN_GEN_BAYER_EN
      if (m < 2 && (col % 2) == 1 && (row % 2) == 1) pd = ((1 << PIX_W) - 1) - pd;
`endif
      if (!pe_e) pd = 0;
      fce  = fd_e ? (fc + 1) % 65536 : fc;
      fc16 = 16'(fce);
      pd_v = PIX_W'(pd);
      return {fv_e, lv_e, pe_e, fd_e, fc16, pd_v};
   endfunction

   // Starts from idle, runs n frames using mode_seq, drops enable at drop_k of the last frame.
   task automatic run_frames(input int n, input int drop_k, input string tag);
      logic [VW-1:0] got, exp;
      int lv_cnt, pe_cnt;
      mode   = 2'(mode_seq[0]);
      enable = 1'b1;
      @(negedge clk);
      got = {fv, lv, pix_en, frame_done, frame_count, pix_data};
      exp = {4'b0, 16'(fc_model), {PIX_W{1'b0}}};
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s start_latency got=%h exp=%h", tag, got, exp);
      end
      for (int f = 0; f < n; f++) begin
         lv_cnt = 0;
         pe_cnt = 0;
         for (int k = 0; k < FTOT; k++) begin
            @(negedge clk);
            got = {fv, lv, pix_en, frame_done, frame_count, pix_data};
            exp = exp_vec(k, mode_seq[f], fc_model);
            total++;
            if (got !== exp) begin
               bad++;
               $display("FAIL %s f=%0d x=%0d y=%0d got=%h exp=%h", tag, f, k % HTOT, k / HTOT, got, exp);
            end
            lv_cnt += int'(lv);
            pe_cnt += int'(pix_en);
            if (k == FTOT / 2 && f + 1 < n) mode = 2'(mode_seq[f + 1]);
            if (f == n - 1 && k == drop_k) enable = 1'b0;
         end
         fc_model = (fc_model + 1) % 65536;
         total++;
         if (lv_cnt != VPIX * (HTOT - HSYNC) || pe_cnt != VPIX * HPIX) begin
            bad++;
            $display("FAIL %s line_counts f=%0d lv=%0d pix_en=%0d exp lv=%0d pix_en=%0d",
                     tag, f, lv_cnt, pe_cnt, VPIX * (HTOT - HSYNC), VPIX * HPIX);
         end
      end
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         got = {fv, lv, pix_en, frame_done, frame_count, pix_data};
         exp = {4'b0, 16'(fc_model), {PIX_W{1'b0}}};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL %s idle_hold i=%0d got=%h exp=%h", tag, i, got, exp);
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      enable  = 1'b0;
      mode    = 2'd0;
      repeat (3) @(negedge clk);
      total++;
      if ({fv, lv, pix_en, frame_done} !== 4'b0) begin
         bad++;
         $display("FAIL reset_flags got=%b exp=0000", {fv, lv, pix_en, frame_done});
      end
      total++;
      if (pix_data !== '0) begin
         bad++;
         $display("FAIL reset_pix_data got=%h exp=0", pix_data);
      end
      total++;
      if (frame_count !== 16'd0) begin
         bad++;
         $display("FAIL reset_frame_count got=%h exp=0", frame_count);
      end
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      total++;
      if ({fv, lv, pix_en, frame_done, frame_count, pix_data} !== '0) begin
         bad++;
         $display("FAIL idle_no_enable got=%h exp=0", {fv, lv, pix_en, frame_done, frame_count, pix_data});
      end
      fc_model = 0;
   endtask

   task automatic test_bars();
      mode_seq[0] = 0;
      run_frames(1, $urandom_range(FTOT - 2, 0), "bars");
   endtask

   task automatic test_ramp();
      mode_seq[0] = 1;
      mode_seq[1] = 1;
      run_frames(2, $urandom_range(FTOT - 2, 0), "ramp");
   endtask

   task automatic test_mode_switch();
      mode_seq[0] = 0;
      mode_seq[1] = 2;
      run_frames(2, 3 * HTOT, "mode_switch");
   endtask

   task automatic test_scroll();
      mode_seq[0] = 3;
      mode_seq[1] = 3;
      mode_seq[2] = 3;
      run_frames(3, $urandom_range(FTOT - 2, 0), "scroll");
   endtask

   task automatic test_random();
      for (int r = 0; r < 3; r++) begin
         int n;
         n = $urandom_range(3, 1);
         for (int f = 0; f < n; f++) mode_seq[f] = $urandom_range(3, 0);
         run_frames(n, $urandom_range(FTOT - 2, 0), "random");
      end
   endtask

   task automatic test_reset_mid();
      mode   = 2'd1;
      enable = 1'b1;
      repeat (3 * HTOT + 20) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      total++;
      if ({fv, lv, pix_en, frame_done, frame_count, pix_data} !== '0) begin
         bad++;
         $display("FAIL async_reset got=%h exp=0", {fv, lv, pix_en, frame_done, frame_count, pix_data});
      end
      enable = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      fc_model    = 0;
      mode_seq[0] = 3;
      run_frames(1, FTOT / 3, "after_reset");
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      reset_n = 1'b0;
      enable  = 1'b0;
      mode    = 2'd0;
      test_reset();
      test_bars();
      test_ramp();
      test_mode_switch();
      test_scroll();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
